wb_result_demux: RTL and testbench

Registered 1-to-4 write-back demultiplexer for the CPU54 datapath, the distribution counterpart of the 8-way operand/PC selectors. It accepts one 32-bit result per cycle with a 3-bit destination code, buffers it in a 2-entry FIFO, and delivers it on exactly one of four destination channels under a valid/ready handshake. It sits between the execute stage and the destination sinks: register file, HI, LO and CP0. Code 4 is a legal discard, mirroring the constant-zero slot of the selectors. Codes 5-7 are illegal and flagged.

---
 rtl/wb_result_demux.sv | 117 +++++++++++
 tb/tb_wb_result_demux.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_demux.sv
// Registered 1-to-4 write-back demultiplexer: 2-entry input FIFO feeding a one-word
// output register with one-hot channel valid, plus delivery/drop counters and illegal-code flag.
module wb_result_demux #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [2:0]  i_in_sel,
    input  logic [31:0] i_in_data,
    output logic [3:0]  o_out_valid,
    input  logic [3:0]  i_out_ready,
    output logic [31:0] o_out_data,
    output logic [15:0] o_deliv_cnt,
    output logic [7:0]  o_drop_cnt,
    output logic        o_err,
    output logic [2:0]  o_err_sel
);

    logic [2:0]  r_fifo_sel  [DEPTH];
    logic [31:0] r_fifo_data [DEPTH];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [3:0]  r_out_valid;
    logic [31:0] r_out_data;
    logic [15:0] r_deliv_cnt;
    logic [7:0]  r_drop_cnt;
    logic        r_err;
    logic [2:0]  r_err_sel;

    logic        w_push;
    logic        w_head_valid;
    logic [2:0]  w_head_sel;
    logic [31:0] w_head_data;
    logic        w_xfer;
    logic        w_drop;
    logic        w_illegal;
    logic        w_load;
    logic        w_pop;

    // in_ready depends only on registered occupancy, never on out_ready
    assign o_in_ready   = (32'(r_count) < DEPTH);
    assign w_push       = i_in_valid && o_in_ready;
    assign w_head_valid = (r_count != 2'd0);
    assign w_head_sel   = r_fifo_sel[r_rptr];
    assign w_head_data  = r_fifo_data[r_rptr];
    assign w_xfer       = |(r_out_valid & i_out_ready);

    // Discards never touch the output register, so they may pop past a stalled word
    assign w_drop    = w_head_valid && w_head_sel[2];
    assign w_illegal = w_drop && (w_head_sel[1:0] != 2'd0);
    assign w_load    = w_head_valid && !w_head_sel[2] && ((r_out_valid == 4'd0) || w_xfer);
    assign w_pop     = w_drop || w_load;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_sel[r_wptr]  <= i_in_sel;
            r_fifo_data[r_wptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_out_valid <= 4'd0;
            r_out_data  <= 32'd0;
            r_deliv_cnt <= 16'd0;
            r_drop_cnt  <= 8'd0;
            r_err       <= 1'b0;
            r_err_sel   <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end

            if (w_load) begin
                r_out_valid <= 4'b0001 << w_head_sel[1:0];
                r_out_data  <= w_head_data;
            end else if (w_xfer) begin
                r_out_valid <= 4'd0;
            end

            if (w_xfer) begin
                r_deliv_cnt <= r_deliv_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_sel <= w_head_sel;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_deliv_cnt = r_deliv_cnt;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_err       = r_err;
    assign o_err_sel   = r_err_sel;

endmodule

// File: tb/tb_wb_result_demux.sv
// Bench for wb_result_demux: directed scenarios plus a randomized run checked
// against an ordered queue of expected deliveries and abstract counters.
module tb_wb_result_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [15:0] deliv_cnt;
    logic [7:0]  drop_cnt;
    logic        err;
    logic [2:0]  err_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    wb_result_demux #(.DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_sel    (in_sel),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_deliv_cnt (deliv_cnt),
        .o_drop_cnt  (drop_cnt),
        .o_err       (err),
        .o_err_sel   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = 3'd0;
        in_data = 32'd0;
        out_ready = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; in_sel = 3'd5; in_data = $urandom; tick();
        in_sel = 3'd0; in_data = $urandom; tick();
        in_sel = 3'd1; in_data = $urandom; tick();
        in_valid = 1'b0; tick();
        checks++;
        if (drop_cnt !== 8'd1 || err !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: drop=%0d err=%b, expected drop=1 err=1", drop_cnt, err);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (out_valid !== 4'd0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b data=%h, expected 0000/1/0",
                     out_valid, in_ready, out_data);
        end
        checks++;
        if (deliv_cnt !== 16'd0 || drop_cnt !== 8'd0 || err !== 1'b0 || err_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_counters: deliv=%0d drop=%0d err=%b err_sel=%0d, expected all 0",
                     deliv_cnt, drop_cnt, err, err_sel);
        end
        tick(); tick();
        checks++;
        if (out_valid !== 4'd0) begin
            errors++;
            $display("FAIL reset_lost: valid=%b, expected 0000", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [3:0]  ev;
        logic [31:0] ed;
        do_reset();
        out_ready = 4'hF;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            in_sel = 3'(c);
            in_data = 32'h11111111 * (c + 1);
            tick();
            if (c >= 1 && c <= 4) begin
                ev = 4'b0001 << (c - 1);
                ed = 32'h11111111 * c;
            end else begin
                ev = 4'd0;
                ed = out_data;
            end
            checks++;
            if (out_valid !== ev || out_data !== ed || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_c%0d: valid=%b data=%h ready=%b, expected %b %h 1",
                         c, out_valid, out_data, in_ready, ev, ed);
            end
        end
        checks++;
        if (deliv_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stream_deliv: got %0d expected 4", deliv_cnt);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [31:0] got[$];
        do_reset();
        out_ready = 4'd0;
        for (int c = 0; c < 6; c++) begin
            logic was_ready;
            in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hA0 + acc;
            was_ready = in_ready;
            tick();
            if (was_ready) begin
                acc++;
                checks++;
                if (in_ready !== (acc < 3)) begin
                    errors++;
                    $display("FAIL bp_ready_acc%0d: got %b expected %b", acc, in_ready, acc < 3);
                end
            end
        end
        checks++;
        if (acc != 3 || out_valid !== 4'b0010 || out_data !== 32'hA0) begin
            errors++;
            $display("FAIL bp_hold: acc=%0d valid=%b data=%h, expected 3 0010 000000a0",
                     acc, out_valid, out_data);
        end
        out_ready = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            in_valid = (acc < 4); in_sel = 3'd1; in_data = 32'hA0 + acc;
            if (out_valid[1]) got.push_back(out_data);
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 4 || deliv_cnt !== 16'd4) begin
            errors++;
            $display("FAIL bp_count: got %0d words deliv=%0d, expected 4 4", got.size(), deliv_cnt);
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== 32'hA0 + i) begin
                errors++;
                $display("FAIL bp_order%0d: got %h expected %h", i, got[i], 32'hA0 + i);
            end
        end
    endtask

    task automatic test_discard();
        logic [2:0] sels [4];
        int idx = 0;
        int nout = 0;
        sels = '{3'd4, 3'd6, 3'd5, 3'd0};
        do_reset();
        out_ready = 4'hF;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 4);
            in_sel = (idx < 4) ? sels[idx] : 3'd0;
            in_data = (idx == 3) ? 32'hDEADBEEF : $urandom;
            if (out_valid !== 4'd0) begin
                nout++;
                checks++;
                if (out_valid !== 4'b0001 || out_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL discard_out: valid=%b data=%h, expected 0001 deadbeef",
                             out_valid, out_data);
                end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 1 || deliv_cnt !== 16'd1 || drop_cnt !== 8'd3 || err !== 1'b1 || err_sel !== 3'd6)
        begin
            errors++;
            $display("FAIL discard_state: nout=%0d deliv=%0d drop=%0d err=%b err_sel=%0d, expected 1 1 3 1 6",
                     nout, deliv_cnt, drop_cnt, err, err_sel);
        end
        in_valid = 1'b1; in_sel = 3'd7; tick();
        in_valid = 1'b0; tick(); tick();
        checks++;
        if (err_sel !== 3'd6 || drop_cnt !== 8'd4 || err !== 1'b1) begin
            errors++;
            $display("FAIL discard_sticky: err_sel=%0d drop=%0d err=%b, expected 6 4 1",
                     err_sel, drop_cnt, err);
        end
    endtask

    task automatic test_wrong_ready();
        do_reset();
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h22222222; tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5 && out_valid == 4'd0; c++) tick();
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (out_valid !== 4'b0100 || out_data !== 32'h22222222 || deliv_cnt !== 16'd0) begin
            errors++;
            $display("FAIL wrong_ready_hold: valid=%b data=%h deliv=%0d, expected 0100 22222222 0",
                     out_valid, out_data, deliv_cnt);
        end
        out_ready = 4'b0100;
        tick();
        checks++;
        if (out_valid !== 4'd0 || deliv_cnt !== 16'd1 || out_data !== 32'h22222222) begin
            errors++;
            $display("FAIL wrong_ready_xfer: valid=%b deliv=%0d data=%h, expected 0000 1 22222222",
                     out_valid, deliv_cnt, out_data);
        end
    endtask

    task automatic test_saturation();
        int acc = 0;
        do_reset();
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 3'd4; in_data = 32'h0;
        for (int c = 0; c < 400 && acc < 260; c++) begin
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (acc != 260 || drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_drop: acc=%0d drop=%0d, expected 260 255", acc, drop_cnt);
        end
        acc = 0;
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h33333333;
        for (int c = 0; c < 70000 && acc < 65536; c++) begin
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (acc != 65536 || deliv_cnt !== 16'd0 || drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_wrap: acc=%0d deliv=%0d drop=%0d, expected 65536 0 255",
                     acc, deliv_cnt, drop_cnt);
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          m_drop = 0;
        logic        m_err = 1'b0;
        logic [2:0]  m_err_sel = 3'd0;
        logic [15:0] m_deliv = 16'd0;
        logic [3:0]  pv = 4'd0;
        logic [31:0] pd = 32'd0;
        logic        pstall = 1'b0;
        do_reset();
        for (int c = 0; c < 3050; c++) begin
            if (c < 3000) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel = 3'($urandom_range(0, 7));
                in_data = $urandom;
                out_ready = 4'($urandom_range(0, 15));
            end else begin
                in_valid = 1'b0;
                out_ready = 4'hF;
            end
            checks++;
            if (!$onehot0(out_valid)) begin
                errors++;
                $display("FAIL rand_onehot c%0d: valid=%b, expected at most one bit", c, out_valid);
            end
            if (pstall) begin
                checks++;
                if (out_valid !== pv || out_data !== pd) begin
                    errors++;
                    $display("FAIL rand_stable c%0d: got %b %h expected %b %h",
                             c, out_valid, out_data, pv, pd);
                end
            end
            if ((out_valid & out_ready) != 4'd0) begin
                checks++;
                m_deliv++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected c%0d: got %b %h expected no delivery",
                             c, out_valid, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_valid !== (4'b0001 << e.ch) || out_data !== e.data) begin
                        errors++;
                        $display("FAIL rand_deliver c%0d: got %b %h expected %b %h",
                                 c, out_valid, out_data, 4'b0001 << e.ch, e.data);
                    end
                end
            end
            pstall = (out_valid != 4'd0) && ((out_valid & out_ready) == 4'd0);
            pv = out_valid;
            pd = out_data;
            if (in_valid && in_ready) begin
                if (in_sel < 3'd4) begin
                    e.ch = in_sel[1:0];
                    e.data = in_data;
                    q.push_back(e);
                end else begin
                    if (m_drop < 255) m_drop++;
                    if (in_sel >= 3'd5 && !m_err) begin
                        m_err = 1'b1;
                        m_err_sel = in_sel;
                    end
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || deliv_cnt !== m_deliv) begin
            errors++;
            $display("FAIL rand_drain: pending=%0d deliv=%0d, expected 0 %0d",
                     q.size(), deliv_cnt, m_deliv);
        end
        checks++;
        if (drop_cnt !== 8'(m_drop) || err !== m_err || err_sel !== m_err_sel) begin
            errors++;
            $display("FAIL rand_counters: drop=%0d err=%b err_sel=%0d, expected %0d %b %0d",
                     drop_cnt, err, err_sel, m_drop, m_err, m_err_sel);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = 3'd0;
        in_data = 32'd0;
        out_ready = 4'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_discard();
        test_wrong_ready();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
